// File: rtl/pc_gen.sv
// Fetch-stage program counter: next-PC selection, delay-slot flag, fetch
// address fault detection and saturating conditional-branch statistics.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_BYTES = 32'h0000_4000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             d_valid,
  input  logic [1:0]       d_op,
  input  logic             d_taken,
  input  logic [31:0]      d_pc,
  input  logic [15:0]      d_imm16,
  input  logic [25:0]      d_index26,
  input  logic [31:0]      d_rs,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [31:0]      epc,
  input  logic             cnt_clr,
  output logic [31:0]      pc_f,
  output logic [31:0]      npc,
  output logic             bd_f,
  output logic             fetch_exc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] br_taken_cnt
);

  localparam logic [1:0] OP_SEQ = 2'b00;
  localparam logic [1:0] OP_BR  = 2'b01;
  localparam logic [1:0] OP_J   = 2'b10;
  localparam logic [1:0] OP_JR  = 2'b11;

  localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
  localparam logic [32:0] IM_HI = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v)
      return v;
    else
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic signed [31:0] br_off;
  logic        [31:0] br_target;
  logic        [31:0] j_target;
  logic               advance;
  logic               is_br;
  logic               is_redirect;

  assign br_off      = {{14{d_imm16[15]}}, d_imm16, 2'b00};
  assign br_target   = d_pc + 32'd4 + $unsigned(br_off);
  assign j_target    = {d_pc[31:28], d_index26, 2'b00};
  assign advance     = !stall && !exc_req && !eret_req;
  assign is_br       = d_valid && (d_op == OP_BR);
  assign is_redirect = d_valid && (d_op != OP_SEQ);

  // Next-PC priority: exception, eret, stall hold, D redirect, sequential.
  always_comb begin
    npc = pc_f + 32'd4;
    if (exc_req)
      npc = EXC_PC;
    else if (eret_req)
      npc = epc;
    else if (stall)
      npc = pc_f;
    else if (is_br && d_taken)
      npc = br_target;
    else if (d_valid && d_op == OP_J)
      npc = j_target;
    else if (d_valid && d_op == OP_JR)
      npc = d_rs;
  end

  // Widened compare keeps IM_BASE + IM_BYTES from wrapping at the top of memory.
  assign fetch_exc = (pc_f[1:0] != 2'b00)
                  || ({1'b0, pc_f} < IM_LO)
                  || ({1'b0, pc_f} >= IM_HI);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_f <= RESET_PC;
      bd_f <= 1'b0;
    end else begin
      pc_f <= npc;
      if (exc_req || eret_req)
        bd_f <= 1'b0;
      else if (!stall)
        bd_f <= is_redirect;
    end
  end

  // Clear dominates any same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_cnt       <= '0;
      br_taken_cnt <= '0;
    end else if (cnt_clr) begin
      br_cnt       <= '0;
      br_taken_cnt <= '0;
    end else if (advance && is_br) begin
      br_cnt <= sat_inc(br_cnt);
      if (d_taken)
        br_taken_cnt <= sat_inc(br_taken_cnt);
    end
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Fetch-stage program-counter unit for the pipelined MIPS core: it owns the F-stage PC register and computes the next fetch address. Sources are, in priority order, exception entry, `eret` return, stall hold, D-stage branch/jump redirect, and sequential fetch. It also provides the branch-delay-slot flag for CP0, an instruction-fetch address fault flag, and saturating branch statistics counters. It generalises the old combinational next-PC logic with parametrised address map, registered state and exception handling.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded by reset.
- `EXC_PC`, 32'h0000_4180, exception handler entry.
- `IM_BASE`, 32'h0000_3000, lowest legal fetch address.
- `IM_BYTES`, 32'h0000_4000, size of legal fetch window; legal range is [IM_BASE, IM_BASE+IM_BYTES).
- `CNT_W`, 16, width of each statistics counter (2..32).

- `clk` in 1: clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hazard stall; F and D hold.
- `d_valid` in 1: D stage holds a real instruction.
- `d_op` in 2: 00 sequential, 01 conditional branch, 10 `j`/`jal`, 11 `jr`/`jalr`.
- `d_taken` in 1: branch condition result; meaningful only when `d_op`=01.
- `d_pc` in 32: PC of the D-stage instruction.
- `d_imm16` in 16: branch offset field.
- `d_index26` in 26: jump index field.
- `d_rs` in 32: forwarded rs value for `jr`/`jalr`.
- `exc_req` in 1: take exception this cycle.
- `eret_req` in 1: execute `eret` this cycle.
- `epc` in 32: return address for `eret`.
- `cnt_clr` in 1: synchronous clear of both counters.
- `pc_f` out 32: current fetch PC (registered).
- `npc` out 32: value `pc_f` takes at the next edge (combinational).
- `bd_f` out 1: F-stage instruction is a delay slot (registered).
- `fetch_exc` out 1: `pc_f` misaligned or outside the legal window (combinational from `pc_f`).
- `br_cnt` out CNT_W: conditional branches retired through D.
- `br_taken_cnt` out CNT_W: taken conditional branches.

## Operation
- `npc` is selected by the first matching rule:
  - `exc_req`: `EXC_PC`.
  - `eret_req`: `epc`.
  - `stall`: `pc_f`.
  - `d_valid` and `d_op`=01 and `d_taken`: `d_pc + 4 + {sext(d_imm16), 2'b00}`, modulo 2^32.
  - `d_valid` and `d_op`=10: `{d_pc[31:28], d_index26, 2'b00}`.
  - `d_valid` and `d_op`=11: `d_rs`, used unmodified; misalignment is not masked.
  - Otherwise: `pc_f + 4`, modulo 2^32. A not-taken branch also falls here, so fetch continues past the delay slot.
- `pc_f <= npc` every cycle.
- "Advance" means none of `stall`, `exc_req` or `eret_req` is set.
- `bd_f`:
  - On exception or `eret`: 0.
  - On stall: hold.
  - On advance: `d_valid && d_op != 00`.
- `fetch_exc` = `pc_f[1:0] != 0` or `pc_f < IM_BASE` or `pc_f >= IM_BASE + IM_BYTES`. Compare with 33-bit arithmetic so the sum cannot wrap.
- Counters:
  - On advance with `d_valid` and `d_op`=01: `br_cnt` increments, and `br_taken_cnt` also increments if `d_taken`.
  - Both counters saturate at all-ones and never wrap.
  - `cnt_clr` zeroes both counters and beats a same-cycle increment.
- `d_op` values other than 00 are ignored when `d_valid`=0.

## Timing
- Reset (async assert): `pc_f`=`RESET_PC`, `bd_f`=0, `br_cnt`=0, `br_taken_cnt`=0. After reset, `npc`=`RESET_PC+4` and `fetch_exc`=0 with default parameters.
- Deassertion of `reset_n` is synchronous to `clk` (external synchroniser). The first edge with `reset_n`=1 loads `npc`.
- Redirect latency is one cycle: a D-stage jump seen at edge N appears on `pc_f` after edge N. The delay-slot instruction is fetched at edge N-1, so no bubble is inserted.
- `exc_req` and `eret_req` override `stall` in the same cycle. If both are high, `exc_req` wins and `epc` is ignored.
- Reset asserted mid-stall or mid-redirect discards all pending state immediately.
- `fetch_exc` is valid in the same cycle as `pc_f`. The block keeps fetching; the fault is reported downstream and is not acted on here.

## Test plan
- Reset, then 3 free-running cycles: `pc_f` reads 0x3000, 0x3004, 0x3008, 0x300C; `bd_f`=0; `fetch_exc`=0.
- `d_pc`=0x3010, `d_op`=01, `d_taken`=1, `d_imm16`=16'hFFFC: next `pc_f`=0x3004, `bd_f`=1, both counters=1. Repeat with `d_taken`=0: next `pc_f`=old `pc_f`+4, `br_cnt`=2, `br_taken_cnt`=1.
- `d_op`=11, `d_rs`=0x0000_3002: `pc_f`=0x3002 and `fetch_exc`=1. Then `d_op`=10, `d_pc`=0x3004, `d_index26`=26'h0C00: `pc_f`=0x3000.
- `stall`=1 together with `d_op`=10 for 2 cycles: `pc_f` and `bd_f` hold. `stall`=1 with `exc_req`=1: `pc_f`=0x4180, `bd_f`=0. `exc_req`=`eret_req`=1 with `epc`=0x3100: `pc_f`=0x4180.
- Use `CNT_W`=2 and 5 taken branches: both counters reach 3 and stay there. `cnt_clr` asserted on the same cycle as a branch: both counters read 0.
- Assert `reset_n`=0 between clock edges while `pc_f`=0x4180: `pc_f`=0x3000 immediately, without waiting for a clock edge.
